// File: rtl/mux_arb_pkg.sv
// Shared definitions for the 2-to-1 select arbiter.
//   arb_state_e  : arbiter FSM encoding (IDLE / OWN0 / OWN1)
//   MAX_HOLD_DEF : default maximum consecutive grant cycles under contention
//   CNT_W_DEF    : default hold counter width
package mux_arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OWN0 = 2'd1,
    OWN1 = 2'd2
  } arb_state_e;

  localparam int unsigned MAX_HOLD_DEF = 4;
  localparam int unsigned CNT_W_DEF    = 3;

endpackage : mux_arb_pkg

// File: rtl/mux_hold_counter.sv
// Hold counter for the arbiter: clears on request, counts up while enabled
// and saturates at MAX_HOLD-1.
//   clk, rst_n : clock, asynchronous active-low reset
//   clr        : force the count to zero (priority over en)
//   en         : advance the count by one, saturating
//   cnt        : current count (registered)
module mux_hold_counter #(
  parameter int unsigned MAX_HOLD = 4,
  parameter int unsigned CNT_W    = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             en,
  output logic [CNT_W-1:0] cnt
);

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_HOLD - 1);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  // Next count: clear wins, otherwise saturating increment
  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en && (cnt_q != CNT_MAX)) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt = cnt_q;

endmodule : mux_hold_counter

// File: rtl/mux_select_arbiter.sv
// Two-requester round-robin arbiter with bounded hold, driving the select of
// an external 2-to-1 multiplexer.
//   clk, rst_n : clock, asynchronous active-low reset
//   req0, req1 : requests for the shared path (I0 / I1)
//   gnt0, gnt1 : registered grants, one-hot or idle
//   S          : registered mux select (0 = I0, 1 = I1), held while idle
//   busy       : registered gnt0 | gnt1
module mux_select_arbiter
  import mux_arb_pkg::*;
#(
  parameter int unsigned MAX_HOLD = MAX_HOLD_DEF,
  parameter int unsigned CNT_W    = CNT_W_DEF
) (
  input  logic clk,
  input  logic rst_n,
  input  logic req0,
  input  logic req1,
  output logic gnt0,
  output logic gnt1,
  output logic S,
  output logic busy
);

  arb_state_e       state_q, state_d;
  logic             last_q, last_d;
  logic             gnt0_q, gnt0_d;
  logic             gnt1_q, gnt1_d;
  logic             s_q, s_d;
  logic             busy_q, busy_d;
  logic [CNT_W-1:0] hold_cnt;
  logic             hold_max;
  logic             cnt_clr;
  logic             cnt_en;

  assign hold_max = (hold_cnt == CNT_W'(MAX_HOLD - 1));

  // Count restarts on every OWN entry and stays at zero while idle
  assign cnt_clr = (state_d != state_q) || (state_d == IDLE);
  assign cnt_en  = (state_q != IDLE);

  mux_hold_counter #(
    .MAX_HOLD (MAX_HOLD),
    .CNT_W    (CNT_W)
  ) u_hold_counter (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (cnt_clr),
    .en    (cnt_en),
    .cnt   (hold_cnt)
  );

  // Next-state and registered-output decode
  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    s_d     = s_q;

    case (state_q)
      IDLE: begin
        if (req0 && req1) begin
          state_d = last_q ? OWN0 : OWN1;
        end else if (req0) begin
          state_d = OWN0;
        end else if (req1) begin
          state_d = OWN1;
        end
      end
      // Release takes precedence; preemption only while still requesting
      OWN0: begin
        if (!req0) begin
          state_d = req1 ? OWN1 : IDLE;
        end else if (req1 && hold_max) begin
          state_d = OWN1;
        end
      end
      OWN1: begin
        if (!req1) begin
          state_d = req0 ? OWN0 : IDLE;
        end else if (req0 && hold_max) begin
          state_d = OWN0;
        end
      end
      default: state_d = IDLE;
    endcase

    if (state_d == OWN0) begin
      last_d = 1'b0;
      s_d    = 1'b0;
    end else if (state_d == OWN1) begin
      last_d = 1'b1;
      s_d    = 1'b1;
    end

    gnt0_d = (state_d == OWN0);
    gnt1_d = (state_d == OWN1);
    busy_d = gnt0_d | gnt1_d;
  end

  // Last-served resets to 1 so requester 0 wins the first tie
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      last_q  <= 1'b1;
      gnt0_q  <= 1'b0;
      gnt1_q  <= 1'b0;
      s_q     <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      gnt0_q  <= gnt0_d;
      gnt1_q  <= gnt1_d;
      s_q     <= s_d;
      busy_q  <= busy_d;
    end
  end

  assign gnt0 = gnt0_q;
  assign gnt1 = gnt1_q;
  assign S    = s_q;
  assign busy = busy_q;

endmodule : mux_select_arbiter

// File: tb/tb_mux_select_arbiter.sv
// Directed bench for mux_select_arbiter: instance a uses MAX_HOLD = 4,
// instance b uses MAX_HOLD = 1. Outputs are compared as {gnt0,gnt1,S,busy}.
module tb_mux_select_arbiter;

  logic clk = 1'b0;
  logic rst_n;
  logic req0;
  logic req1;
  logic a_g0, a_g1, a_s, a_busy;
  logic b_g0, b_g1, b_s, b_busy;

  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;

  always #5 clk = ~clk;

  mux_select_arbiter #(.MAX_HOLD(4), .CNT_W(3)) dut_a (
    .clk (clk), .rst_n (rst_n), .req0 (req0), .req1 (req1),
    .gnt0 (a_g0), .gnt1 (a_g1), .S (a_s), .busy (a_busy)
  );

  mux_select_arbiter #(.MAX_HOLD(1), .CNT_W(3)) dut_b (
    .clk (clk), .rst_n (rst_n), .req0 (req0), .req1 (req1),
    .gnt0 (b_g0), .gnt1 (b_g1), .S (b_s), .busy (b_busy)
  );

  // Grant exclusivity and busy consistency on both instances every cycle
  always @(negedge clk) begin
    assert (!(a_g0 && a_g1) && (a_busy == (a_g0 | a_g1)))
      else $error("FAIL assert_a: gnt0=%b gnt1=%b busy=%b", a_g0, a_g1, a_busy);
    assert (!(b_g0 && b_g1) && (b_busy == (b_g0 | b_g1)))
      else $error("FAIL assert_b: gnt0=%b gnt1=%b busy=%b", b_g0, b_g1, b_busy);
  end

  task automatic check(input string tag, input logic [3:0] got, input logic [3:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %b expected %b", tag, got, exp);
  endtask

  function automatic logic [3:0] a_out();
    return {a_g0, a_g1, a_s, a_busy};
  endfunction

  function automatic logic [3:0] b_out();
    return {b_g0, b_g1, b_s, b_busy};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Pulse reset between edges and confirm outputs clear without a clock
  task automatic pulse_reset(input string tag);
    rst_n = 1'b0;
    #1;
    check(tag, a_out(), 4'b0000);
    rst_n = 1'b1;
  endtask

  localparam logic [3:0] G0   = 4'b1001;  // gnt0, S=0, busy
  localparam logic [3:0] G1   = 4'b0111;  // gnt1, S=1, busy
  localparam logic [3:0] IDL0 = 4'b0000;  // idle, S=0
  localparam logic [3:0] IDL1 = 4'b0010;  // idle, S held at 1

  initial begin
    rst_n = 1'b0;
    req0  = 1'b0;
    req1  = 1'b0;
    #2;
    check("reset_a", a_out(), IDL0);
    check("reset_b", b_out(), IDL0);
    #10 rst_n = 1'b1;
    tick();
    check("idle_no_req", a_out(), IDL0);

    // Sole requester 0: one-cycle grant latency, release to idle keeps S=0
    req0 = 1'b1;
    tick();
    check("req0_grant", a_out(), G0);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("req0_hold", a_out(), G0);
    end
    req0 = 1'b0;
    tick();
    check("req0_release", a_out(), IDL0);

    // Tie from reset: requester 0 first, then 4/4 alternation
    pulse_reset("reset_mid");
    req0 = 1'b1;
    req1 = 1'b1;
    for (int i = 0; i < 12; i++) begin
      tick();
      check($sformatf("tie_rr_%0d", i), a_out(), (((i / 4) % 2) == 0) ? G0 : G1);
    end

    // OWN0 release with req1 pending: straight to OWN1, no idle gap
    req0 = 1'b0;
    tick();
    check("own0_to_own1", a_out(), G1);
    // OWN1 release with req0 pending: S 1 -> 0, busy stays high
    req0 = 1'b1;
    req1 = 1'b0;
    tick();
    check("own1_to_own0", a_out(), G0);

    // Sole requester holds beyond MAX_HOLD; counter must saturate
    for (int i = 0; i < 8; i++) begin
      tick();
      check("sole_hold", a_out(), G0);
    end
    req1 = 1'b1;
    tick();
    check("preempt_after_long", a_out(), G1);

    // Idle keeps S at 1; tie with last-served = 1 goes to requester 0
    req0 = 1'b0;
    req1 = 1'b0;
    tick();
    check("idle_hold_s", a_out(), IDL1);
    req0 = 1'b1;
    req1 = 1'b1;
    tick();
    check("tie_last1", a_out(), G0);

    // Reset pulse mid-OWN1, grant back one edge after release
    req0 = 1'b0;
    tick();
    check("own1_pre_rst", a_out(), G1);
    #2;
    rst_n = 1'b0;
    #1;
    check("rst_drop_own1", a_out(), IDL0);
    #1;
    rst_n = 1'b1;
    tick();
    check("regrant_after_rst", a_out(), G1);

    // MAX_HOLD = 1 alternates every cycle under constant contention
    req0 = 1'b0;
    req1 = 1'b0;
    pulse_reset("reset_b_pre");
    check("reset_b_idle", b_out(), IDL0);
    req0 = 1'b1;
    req1 = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick();
      check($sformatf("b_alt_%0d", i), b_out(), ((i % 2) == 0) ? G0 : G1);
    end
    req0 = 1'b0;
    req1 = 1'b0;
    tick();
    check("b_idle_end", b_out(), IDL1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule : tb_mux_select_arbiter

// File: doc/mux_select_arbiter.md
MUX_SELECT_ARBITER -- requirements
Module: mux_select_arbiter

Interface
REQ-001 Parameter MAX_HOLD, default 4: maximum consecutive grant cycles for one requester while the other requests; legal range 1..8.
REQ-002 Parameter CNT_W, default 3: hold counter width; SHALL satisfy 2**CNT_W >= MAX_HOLD.
REQ-003 clk  input  1  single clock; all state changes on its rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 req0  input  1  requester 0 asks for the shared 2-to-1 path (selects input I0).
REQ-006 req1  input  1  requester 1 asks for the shared 2-to-1 path (selects input I1).
REQ-007 gnt0  output  1  requester 0 owns the path this cycle.
REQ-008 gnt1  output  1  requester 1 owns the path this cycle.
REQ-009 S  output  1  select for the external 2-to-1 multiplexer; 0 = I0, 1 = I1.
REQ-010 busy  output  1  gnt0 | gnt1.

Function
REQ-011 FSM states: IDLE, OWN0, OWN1; all outputs SHALL be registered or decoded only from registered state.
REQ-012 Grant latency SHALL be exactly 1 cycle: a request sampled at edge N in IDLE gives its grant after edge N.
REQ-013 IDLE: req0 only -> OWN0; req1 only -> OWN1; neither -> IDLE.
REQ-014 IDLE with req0 and req1 -> the requester not recorded in the last-served pointer (round-robin).
REQ-015 OWNx: stay while reqx = 1 and no preemption applies.
REQ-016 OWNx, reqx = 0: go to the other OWN state if the other request is 1 (no idle bubble), else IDLE.
REQ-017 Preemption: in OWNx, when the other request = 1 and hold_cnt = MAX_HOLD-1, go to the other OWN state even if reqx = 1.
REQ-018 hold_cnt SHALL clear to 0 on every entry into an OWN state, increment each cycle in OWN, and saturate at MAX_HOLD-1; it is 0 in IDLE.
REQ-019 The last-served pointer SHALL update to x on every entry into OWNx.
REQ-020 gnt0 = (state = OWN0), gnt1 = (state = OWN1); both high SHALL never occur.
REQ-021 S SHALL be 0 in OWN0 and 1 in OWN1, and SHALL hold its last value in IDLE so the datapath stays stable.
REQ-022 Release and preemption in the same cycle SHALL be treated as release (REQ-016).
REQ-023 MAX_HOLD = 1 with both requests continuously high SHALL alternate the grant every cycle.
REQ-024 A sole requester SHALL hold the grant indefinitely; preemption applies only when the other requests.

Reset
REQ-025 rst_n low SHALL immediately, without a clock, force state = IDLE, gnt0 = 0, gnt1 = 0, busy = 0, S = 0, hold_cnt = 0, last-served = 1, so requester 0 wins the first tie.
REQ-026 Reset asserted mid-grant SHALL drop the grant in the same cycle; after rst_n rises, arbitration restarts from IDLE at the next edge.

Structure
REQ-027 Package mux_arb_pkg SHALL hold the state encoding constants (IDLE = 2'd0, OWN0 = 2'd1, OWN1 = 2'd2) and the MAX_HOLD default.
REQ-028 One sub-module, mux_hold_counter (clear, enable, saturating at MAX_HOLD-1, async active-low reset), SHALL implement hold_cnt.
REQ-029 The block SHALL NOT contain the multiplexer itself; it SHALL drive S to an external 2-to-1 multiplexer.

Verification
REQ-030 Reset, then req0 = 1 at cycle 2 -> gnt0 = 1, S = 0, busy = 1 from cycle 3; req0 = 0 at cycle 6 -> gnt0 = 0 from cycle 7, S stays 0.
REQ-031 From reset, req0 = req1 = 1 in the same cycle -> gnt0 first; with MAX_HOLD = 4 the grant runs 4 cycles of gnt0, then 4 of gnt1, repeating, and S toggles with it.
REQ-032 OWN1 with req1 falling while req0 = 1 -> gnt0 on the next cycle with no busy = 0 gap; S goes 1 -> 0.
REQ-033 MAX_HOLD = 1, both requests held high for 6 cycles -> gnt pattern 0,1,0,1,0,1.
REQ-034 rst_n pulsed low between edges during OWN1 -> gnt1 = 0 and S = 0 before the next edge; with req1 still 1 after release -> gnt1 again 1 cycle later.
REQ-035 Throughout all scenarios, an assertion SHALL check gnt0 & gnt1 = 0 and busy = gnt0 | gnt1 on every cycle.
